// File: rtl/data_ram_pkg.sv
// Shared bus widths and FSM state encoding for the data RAM.
package data_ram_pkg;

   localparam int unsigned DATA_BUS    = 32;
   localparam int unsigned ADDR_BUS    = 32;
   localparam int unsigned MEM_SEL_BUS = 4;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } ram_state_t;

endpackage

// File: rtl/data_ram_lane.sv
// One byte lane of the data RAM: 8-bit x 2**ADDR_WIDTH, single write port, registered read.
module data_ram_lane #(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [7:0]            wdata,
   output logic [7:0]            rdata
);

   logic [7:0] mem [2**ADDR_WIDTH];

   // Read register only loads on a read so it holds across write/idle cycles.
   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
      if (rd_en)
         rdata <= mem[addr];
   end

endmodule

// File: rtl/data_ram.sv
// Byte-lane-writable data RAM with 1-cycle registered reads.
// Define DATA_RAM_CLEAR_EN to add the post-reset CLEAR_VALUE sweep and ram_busy.
module data_ram
   import data_ram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter logic [31:0] CLEAR_VALUE = 32'h0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ram_en,
   input  logic [MEM_SEL_BUS-1:0] ram_write_en,
   input  logic [ADDR_BUS-1:0]    ram_addr,
   input  logic [DATA_BUS-1:0]    ram_write_data,
   output logic [DATA_BUS-1:0]    ram_read_data,
   output logic                   ram_read_valid,
   output logic                   ram_addr_err,
   output logic                   ram_busy
);

   ram_state_t              state;
   logic                    sweep;
   logic [ADDR_WIDTH-1:0]   clr_cnt;
   logic [ADDR_WIDTH-1:0]   idx;
   logic [ADDR_WIDTH-1:0]   lane_addr;
   logic [DATA_BUS-1:0]     lane_wdata;
   logic [DATA_BUS-1:0]     lane_q;
   logic [MEM_SEL_BUS-1:0]  lane_we;
   logic                    lane_rd;
   logic                    req_ok;
   logic                    is_read;
   logic                    oor;
   logic                    out_zero;
   logic                    unused_addr_lsb;

`ifdef DATA_RAM_CLEAR_EN
   ram_state_t state_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_CLEAR;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == ST_CLEAR && clr_cnt == '1)
         state_nxt = ST_READY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         clr_cnt <= '0;
      else if (sweep)
         clr_cnt <= clr_cnt + 1'b1;
   end
`else
   assign state   = ST_READY;
   assign clr_cnt = '0;
`endif

   assign sweep           = (state == ST_CLEAR);
   assign ram_busy        = sweep;
   assign unused_addr_lsb = ^ram_addr[1:0];

   assign idx     = ram_addr[ADDR_WIDTH+1:2];
   assign oor     = |ram_addr[ADDR_BUS-1:ADDR_WIDTH+2];
   assign req_ok  = ram_en && !sweep;
   assign is_read = (ram_write_en == '0);

   // The sweep owns the array port; MEM-stage requests only reach it when READY.
   assign lane_addr  = sweep ? clr_cnt : idx;
   assign lane_wdata = sweep ? CLEAR_VALUE : ram_write_data;
   assign lane_we    = sweep ? '1 : ((req_ok && !oor) ? ram_write_en : '0);
   assign lane_rd    = req_ok && is_read && !oor;

   for (genvar i = 0; i < MEM_SEL_BUS; i++) begin : g_lane
      data_ram_lane #(
         .ADDR_WIDTH(ADDR_WIDTH)
      ) u_lane (
         .clk   (clk),
         .we    (lane_we[i]),
         .rd_en (lane_rd),
         .addr  (lane_addr),
         .wdata (lane_wdata[8*i +: 8]),
         .rdata (lane_q[8*i +: 8])
      );
   end

   // out_zero forces the reset value and the zero returned by out-of-range reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_read_valid <= 1'b0;
         ram_addr_err   <= 1'b0;
         out_zero       <= 1'b1;
      end else begin
         ram_read_valid <= req_ok && is_read;
         ram_addr_err   <= req_ok && oor;
         if (req_ok && is_read)
            out_zero <= oor;
      end
   end

   assign ram_read_data = out_zero ? '0 : lane_q;

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram (ADDR_WIDTH=4) against a word-array reference model.
module tb_data_ram;

   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 2**AW;

   logic        clk;
   logic        rst_n;
   logic        ram_en;
   logic [3:0]  ram_write_en;
   logic [31:0] ram_addr;
   logic [31:0] ram_write_data;
   logic [31:0] ram_read_data;
   logic        ram_read_valid;
   logic        ram_addr_err;
   logic        ram_busy;

   data_ram #(
      .ADDR_WIDTH  (AW),
      .CLEAR_VALUE (32'h0)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ram_en         (ram_en),
      .ram_write_en   (ram_write_en),
      .ram_addr       (ram_addr),
      .ram_write_data (ram_write_data),
      .ram_read_data  (ram_read_data),
      .ram_read_valid (ram_read_valid),
      .ram_addr_err   (ram_addr_err),
      .ram_busy       (ram_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mem_m [DEPTH];
   logic [31:0] exp_data;
   logic        exp_valid;
   logic        exp_err;
   int          busy_left;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one request, take one clock edge, update the model, compare all outputs.
   task automatic step(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wd);
      bit          dropped;
      bit          out_of_range;
      int unsigned w;
      ram_en         = en;
      ram_write_en   = we;
      ram_addr       = addr;
      ram_write_data = wd;
      @(posedge clk);
      dropped = (busy_left > 0);
      if (busy_left > 0)
         busy_left--;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (en && !dropped) begin
         out_of_range = (addr >= DEPTH * 4);
         w            = addr / 4;
         exp_err      = out_of_range;
         if (we != 4'b0000) begin
            if (!out_of_range)
               for (int i = 0; i < 4; i++)
                  if (we[i])
                     mem_m[w][8*i +: 8] = wd[8*i +: 8];
         end else begin
            exp_valid = 1'b1;
            exp_data  = out_of_range ? 32'h0 : mem_m[w];
         end
      end
      #1;
      check("valid", ram_read_valid, exp_valid);
      check("err",   ram_addr_err,   exp_err);
      check("data",  ram_read_data,  exp_data);
      check("busy",  ram_busy,       (busy_left > 0));
      ram_en = 1'b0;
   endtask

   task automatic do_reset();
      #2;
      rst_n  = 1'b0;
      ram_en = 1'b0;
      #3;
      check("rst_data",  ram_read_data,  32'h0);
      check("rst_valid", ram_read_valid, 1'b0);
      check("rst_err",   ram_addr_err,   1'b0);
`ifdef DATA_RAM_CLEAR_EN
      check("rst_busy",  ram_busy,       1'b1);
`else
      check("rst_busy",  ram_busy,       1'b0);
`endif
      @(negedge clk);
      rst_n    = 1'b1;
      exp_data = 32'h0;
`ifdef DATA_RAM_CLEAR_EN
      busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++)
         mem_m[i] = 32'h0;
`else
      busy_left = 0;
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [3:0]  we;
      logic [31:0] a;
      rst_n          = 1'b1;
      ram_en         = 1'b0;
      ram_write_en   = 4'b0;
      ram_addr       = 32'h0;
      ram_write_data = 32'h0;
      busy_left      = 0;
      exp_data       = 32'h0;
      @(negedge clk);
      do_reset();

`ifdef DATA_RAM_CLEAR_EN
      // Read during the sweep is dropped; busy lasts exactly DEPTH cycles.
      step(1'b1, 4'b0000, 32'h8, 32'h0);
      n = 1;
      while (ram_busy && n < 100) begin
         step(1'b0, 4'b0000, 32'h0, 32'h0);
         n++;
      end
      check("busy_len", n, DEPTH);
      step(1'b1, 4'b0000, 32'h8, 32'h0);
      check("clr_read", ram_read_data, 32'h0);
      check("clr_valid", ram_read_valid, 1'b1);
`endif

      for (int i = 0; i < DEPTH; i++)
         step(1'b1, 4'b1111, i * 4, $urandom);

      // Partial-lane merge.
      step(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF);
      step(1'b1, 4'b0100, 32'h10, 32'h00AA0000);
      step(1'b1, 4'b0000, 32'h10, 32'h0);
      check("merge", ram_read_data, 32'hDEAABEEF);
      check("merge_valid", ram_read_valid, 1'b1);

      // Read-after-write with no bubble, then a hold cycle.
      step(1'b1, 4'b1111, 32'h20, 32'h12345678);
      step(1'b1, 4'b0000, 32'h20, 32'h0);
      check("raw", ram_read_data, 32'h12345678);
      step(1'b0, 4'b0000, 32'h20, 32'h0);
      check("hold", ram_read_data, 32'h12345678);

      // Out-of-range write discarded; out-of-range read returns zero with err.
      step(1'b1, 4'b1111, 32'h0, 32'hCAFEF00D);
      step(1'b1, 4'b1111, 32'h00001000, 32'h11111111);
      check("oor_w_err", ram_addr_err, 1'b1);
      step(1'b1, 4'b0000, 32'h0, 32'h0);
      check("oor_w_word0", ram_read_data, 32'hCAFEF00D);
      step(1'b1, 4'b0000, 32'h00001000, 32'h0);
      check("oor_r_data", ram_read_data, 32'h0);
      check("oor_r_valid", ram_read_valid, 1'b1);
      check("oor_r_err", ram_addr_err, 1'b1);

      // Boundary: last word in range, first word out of range.
      step(1'b1, 4'b1111, 32'h3C, 32'hA5A5_5A5A);
      step(1'b1, 4'b0000, 32'h3F, 32'h0);
      check("last_word", ram_read_data, 32'hA5A5_5A5A);
      step(1'b1, 4'b0000, 32'h40, 32'h0);
      check("first_oor", ram_addr_err, 1'b1);

      // Back-to-back reads.
      step(1'b1, 4'b1111, 32'h0, 32'h0000_0A0A);
      step(1'b1, 4'b1111, 32'h4, 32'h0000_0B0B);
      step(1'b1, 4'b1111, 32'h8, 32'h0000_0C0C);
      step(1'b1, 4'b0000, 32'h0, 32'h0);
      check("b2b_0", ram_read_data, 32'h0000_0A0A);
      step(1'b1, 4'b0000, 32'h4, 32'h0);
      check("b2b_1", ram_read_data, 32'h0000_0B0B);
      step(1'b1, 4'b0000, 32'h8, 32'h0);
      check("b2b_2", ram_read_data, 32'h0000_0C0C);

      for (int k = 0; k < 400; k++) begin
         we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
         a  = ($urandom_range(0, 15) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                            : 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
         step($urandom_range(0, 3) != 0, we, a, $urandom);
      end

`ifdef DATA_RAM_CLEAR_EN
      // Reset mid-sweep restarts the sweep from word 0 for the full depth.
      do_reset();
      for (int k = 0; k < 5; k++)
         step(1'b0, 4'b0000, 32'h0, 32'h0);
      do_reset();
      n = 0;
      while (ram_busy && n < 100) begin
         step(1'b0, 4'b0000, 32'h0, 32'h0);
         n++;
      end
      check("busy_len_restart", n, DEPTH);
`else
      // Memory survives reset when no sweep is built in.
      do_reset();
`endif
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, 4'b0000, i * 4, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-index width (depth = 2**ADDR_WIDTH words, 4 KiB at default).
REQ-002 SHALL have parameter CLEAR_VALUE, default 32'h0, word written by the init-clear sweep.
REQ-003 SHALL use one clock and an asynchronous active-low reset, ports clk then rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ram_en  input  1  request strobe from MEM stage.
REQ-007 ram_write_en  input  4  byte-lane write mask; nonzero means write, zero means read.
REQ-008 ram_addr  input  32  byte address, word-aligned (bits [1:0] ignored).
REQ-009 ram_write_data  input  32  lane-aligned store data.
REQ-010 ram_read_data  output  32  registered load data.
REQ-011 ram_read_valid  output  1  one-cycle pulse qualifying ram_read_data.
REQ-012 ram_addr_err  output  1  one-cycle pulse for an out-of-range access.
REQ-013 ram_busy  output  1  high while the init-clear sweep runs; requests are ignored.

Function
REQ-014 Word index SHALL be ram_addr[ADDR_WIDTH+1:2]; an access is out-of-range when any of ram_addr[31:ADDR_WIDTH+2] is nonzero.
REQ-015 Write: at the edge where ram_en=1 and ram_write_en!=0, each byte lane i with ram_write_en[i]=1 SHALL take ram_write_data[8i+7:8i]; the other lanes are unchanged.
REQ-016 Read: a request at edge N SHALL drive ram_read_data with the stored word and pulse ram_read_valid for exactly the cycle after N (1-cycle latency).
REQ-017 Throughput: one request per cycle. A read issued the cycle after a write to the same word SHALL return the updated word.
REQ-018 A write cycle SHALL hold ram_read_data and keep ram_read_valid low.
REQ-019 An out-of-range write SHALL be discarded. An out-of-range read SHALL return 32'h0 with ram_read_valid=1. Both SHALL pulse ram_addr_err the next cycle.
REQ-020 ram_en=0 SHALL leave memory and ram_read_data unchanged, with ram_read_valid=0 and ram_addr_err=0.
REQ-021 FSM states: CLEAR (sweep), READY (serve). Reset enters CLEAR, or READY when the feature in REQ-026 is absent. CLEAR moves to READY after the last word is written.
REQ-022 In CLEAR, a counter SHALL write CLEAR_VALUE to word k on cycle k (k = 0 .. depth-1) and assert ram_busy; requests from ram_en are dropped without valid or err pulses.
REQ-023 Reset asserted mid-sweep SHALL restart the sweep at word 0 after deassertion.

Reset
REQ-024 On rst_n=0: ram_read_data=0, ram_read_valid=0, ram_addr_err=0, clear counter=0, FSM to its reset state; ram_busy=1 if clear is compiled in, else 0.
REQ-025 Memory contents SHALL NOT be reset by rst_n, except via the sweep.

Configuration
REQ-026 Macro DATA_RAM_CLEAR_EN. Defined: CLEAR state, counter and ram_busy logic are present; ram_busy is high for exactly 2**ADDR_WIDTH cycles after reset release. Undefined: no sweep, FSM is always READY, ram_busy is tied 0, and initial memory contents are undefined.

Structure
REQ-027 DATA_BUS, ADDR_BUS, MEM_SEL_BUS widths and the FSM state encodings SHALL come from the shared bus.v define file.
REQ-028 Storage SHALL be 4 instances of sub-module data_ram_lane (8-bit x depth, single write enable, synchronous read), one per byte lane.

Verification
REQ-029 Reset release with DATA_RAM_CLEAR_EN, ADDR_WIDTH=4 -> ram_busy high 16 cycles; a read of 0x8 issued during the sweep gives no valid; a read of 0x8 after the sweep returns 0x00000000.
REQ-030 Write 0xDEADBEEF mask 4'b1111 at 0x10, then mask 4'b0100 data 0x00AA0000 at 0x10, then read 0x10 -> 0xDEAABEEF with valid on the following cycle.
REQ-031 Write 0x12345678 at 0x20 and read 0x20 on the next cycle -> 0x12345678 one cycle later, no bubble.
REQ-032 ADDR_WIDTH=10: write 0x11111111 at 0x00001000 -> ram_addr_err pulse and word 0 unchanged; read of 0x00001000 -> data 0, valid=1, err=1.
REQ-033 Assert rst_n=0 at sweep word 5, release -> sweep restarts at word 0 and ram_busy lasts the full depth again.
REQ-034 Back-to-back reads of 0x0, 0x4, 0x8 with distinct contents -> three consecutive valid pulses carrying the correct data in order.
